sc_match_scorer: RTL and testbench
==================================

// Module: sc_match_scorer
// PURPOSE
//  Downstream of the per-lane note matchers. Takes the 37 match_trigger pulses and
//  their 16-bit matched note times, converts each to a timing error against
//  song_time, and serialises the events via a round-robin arbiter into one grading
//  pipeline. Maintains score, combo, max combo and multiplier for the display/HUD.
// PARAMETERS
//  LANES      37    number of note lanes (match_trigger width)
//  PERFECT_W  16'd30   |error| <= PERFECT_W -> PERFECT (song_time units)
//  GOOD_W     16'd60   |error| <= GOOD_W    -> GOOD
//  OK_W       16'd100  |error| <= OK_W      -> OK; larger -> MISS
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          asynchronous active-low reset
//  pause          in   1          1 = freeze arbiter/scoring (capture continues)
//  song_time      in   16         current song time
//  match_trigger  in   LANES      per-lane 1-cycle match pulse
//  match_time     in   LANES*16   lane i note time at [16*i+15:16*i]
//  grade_valid    out  1          1-cycle pulse: grade/grade_lane/grade_err valid
//  grade          out  2          0=MISS 1=OK 2=GOOD 3=PERFECT
//  grade_lane     out  6          lane index of graded event (0..LANES-1)
//  grade_err      out  16         |timing error| of graded event
//  score          out  24         running score, saturating
//  combo          out  10         current combo, saturating at 1023
//  max_combo      out  10         highest combo reached
//  multiplier     out  3          1..4
//  drop_count     out  8          events lost to pending overwrite, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): all pending flags 0, arbiter pointer 0, grade_valid 0,
//   grade 0, grade_lane 0, grade_err 0, score 0, combo 0, max_combo 0,
//   multiplier 1, drop_count 0. Mid-pipeline events discarded.
//  Capture (edge E0, regardless of pause): for each i with match_trigger[i]=1:
//   d = (song_time - match_time[i]) mod 2^16; err = d[15] ? -d : d;
//   pend_err[i] <= err, pend[i] <= 1. If pend[i] already 1 and not being drained
//   this same edge: overwrite, drop_count += 1 (saturate 255; several lanes
//   dropping at one edge add their count).
//  Arbiter (edge E1, only when pause=0): pick first pending lane at or after ptr,
//   wrapping 36->0; clear its pend bit (a same-edge trigger on that lane re-sets
//   it, no drop); ptr <= picked+1 (36 wraps to 0).
//   Register grade/err/lane, grade_valid=1 for one cycle. None pending: grade_valid=0.
//  Grade: err<=PERFECT_W ->3; <=GOOD_W ->2; <=OK_W ->1; else 0 (MISS).
//  Score update (edge E2, the edge after grade_valid, even if pause rose):
//   pts = {0,20,50,100}[grade] * multiplier (pre-update multiplier);
//   score <= min(score+pts, 2^24-1);
//   hit (grade!=0): combo <= min(combo+1,1023); MISS: combo <= 0;
//   max_combo <= max(max_combo, new combo);
//   multiplier <= min(1 + new_combo/10, 4).
//  Latency: trigger at E0 -> grade_valid high after E1 (1 cycle, if lane wins) ->
//   score/combo updated after E2. Throughput: one graded event per cycle.
//  Pause: pend bits held, pointer held, grade_valid forced 0; in-flight E2 completes.
//  Simultaneous triggers on k lanes: graded over k consecutive cycles, RR order.
// TESTING
//  1 Reset: hold rst_n=0 -> all outputs at reset values, multiplier=1; release, idle
//    -> grade_valid stays 0.
//  2 song_time=1000, trigger lane 5 with time 990 -> next cycle grade_valid=1,
//    grade=3, grade_err=10, lane=5; following cycle score=100, combo=1.
//  3 Wrap: song_time=16'h0005, note time 16'hFFF0 -> grade_err=21, PERFECT; note
//    time 16'h0100 at song_time 0 -> err=256, MISS, combo->0, score unchanged.
//  4 Lanes 0,3,36 trigger same cycle, ptr=4 -> graded order 36,0,3 on 3 consecutive
//    cycles; ptr ends at 4.
//  5 Lane 7 triggered twice while pause=1 -> drop_count=1, single grade with second
//    error after pause drops.
//  6 Twelve consecutive PERFECTs -> multiplier 2 after 10th hit, score =
//    9*100 + 100 + 2*100 + 2*100 = 1400; combo=12, max_combo=12.

Source files
------------

// File: rtl/sc_match_scorer.sv
// Match scorer: captures per-lane match events, grades them one per cycle through
// a round-robin arbiter, and keeps score, combo, max combo and multiplier for the HUD.
module sc_match_scorer #(
    parameter int          LANES     = 37,
    parameter logic [15:0] PERFECT_W = 16'd30,
    parameter logic [15:0] GOOD_W    = 16'd60,
    parameter logic [15:0] OK_W      = 16'd100,
    parameter int          LANE_W    = $clog2(LANES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pause,
    input  logic [15:0]         song_time,
    input  logic [LANES-1:0]    match_trigger,
    input  logic [LANES*16-1:0] match_time,
    output logic                grade_valid,
    output logic [1:0]          grade,
    output logic [LANE_W-1:0]   grade_lane,
    output logic [15:0]         grade_err,
    output logic [23:0]         score,
    output logic [9:0]          combo,
    output logic [9:0]          max_combo,
    output logic [2:0]          multiplier,
    output logic [7:0]          drop_count
);

    // grade_valid is a single-cycle pulse with no back-pressure: grade, grade_lane
    // and grade_err are meaningful only in the cycle grade_valid is high, and the
    // score stage consumes every pulse unconditionally on the following edge.

    localparam logic [LANE_W:0] LANES_X = (LANE_W+1)'(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANES-1:0]  pend;
    logic [15:0]       pend_err [LANES];
    logic [15:0]       lane_err [LANES];
    logic [LANE_W-1:0] ptr;

    logic              pick_found;
    logic [LANE_W-1:0] pick_idx;
    logic [LANE_W:0]   scan_idx;
    logic              arb_go;
    logic [LANES-1:0]  drain;
    logic [LANES-1:0]  drop;
    logic [LANE_W:0]   drop_pop;
    logic [8:0]        drop_sum;
    logic [15:0]       pick_err;
    logic [1:0]        pick_grade;

    logic [9:0]        new_combo;
    logic [8:0]        pts;
    logic [6:0]        base_pts;
    logic [24:0]       score_sum;

    // Absolute timing error per lane; the 16-bit difference is treated as signed
    // so note times just across the wrap point still give small errors.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [15:0] d;
            d = song_time - match_time[16*i +: 16];
            lane_err[i] = d[15] ? (16'd0 - d) : d;
        end
    end

    // First pending lane at or after ptr, wrapping past the last lane.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < LANES; k++) begin
            scan_idx = {1'b0, ptr} + (LANE_W+1)'(k);
            if (scan_idx >= LANES_X) begin
                scan_idx = scan_idx - LANES_X;
            end
            if (!pick_found && pend[scan_idx[LANE_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[LANE_W-1:0];
            end
        end
    end

    assign arb_go   = pick_found && !pause;
    assign pick_err = pend_err[pick_idx];

    always_comb begin
        drain    = '0;
        drop     = '0;
        drop_pop = '0;
        if (arb_go) begin
            drain[pick_idx] = 1'b1;
        end
        for (int i = 0; i < LANES; i++) begin
            drop[i]  = match_trigger[i] && pend[i] && !drain[i];
            drop_pop = drop_pop + (LANE_W+1)'(drop[i]);
        end
        drop_sum = {1'b0, drop_count} + 9'(drop_pop);
    end

    always_comb begin
        if (pick_err <= PERFECT_W) begin
            pick_grade = 2'd3;
        end else if (pick_err <= GOOD_W) begin
            pick_grade = 2'd2;
        end else if (pick_err <= OK_W) begin
            pick_grade = 2'd1;
        end else begin
            pick_grade = 2'd0;
        end
    end

    // Capture stage runs even while paused; a trigger on the lane being drained
    // this edge simply re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            drop_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                pend_err[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (match_trigger[i]) begin
                    pend[i]     <= 1'b1;
                    pend_err[i] <= lane_err[i];
                end else if (drain[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            grade_valid <= 1'b0;
            grade       <= '0;
            grade_lane  <= '0;
            grade_err   <= '0;
        end else begin
            grade_valid <= arb_go;
            if (arb_go) begin
                ptr        <= (pick_idx == LAST_LANE) ? '0 : pick_idx + 1'b1;
                grade      <= pick_grade;
                grade_lane <= pick_idx;
                grade_err  <= pick_err;
            end
        end
    end

    always_comb begin
        case (grade)
            2'd1:    base_pts = 7'd20;
            2'd2:    base_pts = 7'd50;
            2'd3:    base_pts = 7'd100;
            default: base_pts = 7'd0;
        endcase
        pts       = 9'(base_pts) * 9'(multiplier);
        score_sum = {1'b0, score} + 25'(pts);
        if (grade == 2'd0) begin
            new_combo = '0;
        end else if (combo == 10'd1023) begin
            new_combo = combo;
        end else begin
            new_combo = combo + 10'd1;
        end
    end

    // Score stage consumes every grade pulse, independent of pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
            multiplier <= 3'd1;
        end else if (grade_valid) begin
            score <= score_sum[24] ? 24'hFF_FFFF : score_sum[23:0];
            combo <= new_combo;
            if (new_combo > max_combo) begin
                max_combo <= new_combo;
            end
            if (new_combo >= 10'd30) begin
                multiplier <= 3'd4;
            end else if (new_combo >= 10'd20) begin
                multiplier <= 3'd3;
            end else if (new_combo >= 10'd10) begin
                multiplier <= 3'd2;
            end else begin
                multiplier <= 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sc_match_scorer.sv
// Directed bench for sc_match_scorer: grading, wrap, round-robin order, pause/drop,
// multiplier ramp and combo saturation, with hand-computed expectations.
module tb_sc_match_scorer;

    localparam int LANES = 37;

    logic                clk;
    logic                rst_n;
    logic                pause;
    logic [15:0]         song_time;
    logic [LANES-1:0]    match_trigger;
    logic [LANES*16-1:0] match_time;
    logic                grade_valid;
    logic [1:0]          grade;
    logic [5:0]          grade_lane;
    logic [15:0]         grade_err;
    logic [23:0]         score;
    logic [9:0]          combo;
    logic [9:0]          max_combo;
    logic [2:0]          multiplier;
    logic [7:0]          drop_count;

    int n_total = 0;
    int n_pass  = 0;

    sc_match_scorer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pause        (pause),
        .song_time    (song_time),
        .match_trigger(match_trigger),
        .match_time   (match_time),
        .grade_valid  (grade_valid),
        .grade        (grade),
        .grade_lane   (grade_lane),
        .grade_err    (grade_err),
        .score        (score),
        .combo        (combo),
        .max_combo    (max_combo),
        .multiplier   (multiplier),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        pause         = 1'b0;
        song_time     = '0;
        match_trigger = '0;
        match_time    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic expect_grade(input string name, input logic [5:0] lane,
                                input logic [1:0] g, input logic [15:0] err);
        n_total++;
        if (grade_valid !== 1'b1 || grade_lane !== lane || grade !== g || grade_err !== err)
            $display("FAIL %s: valid=%0b lane=%0d grade=%0d err=%0d, want valid=1 lane=%0d grade=%0d err=%0d",
                     name, grade_valid, grade_lane, grade, grade_err, lane, g, err);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        pause         = 1'b0;
        song_time     = 16'd123;
        match_trigger = '0;
        match_time    = '0;
        tick();
        tick();
        n_total++;
        if (grade_valid !== 1'b0 || grade !== 2'd0 || grade_lane !== 6'd0 || grade_err !== 16'd0 ||
            score !== 24'd0 || combo !== 10'd0 || max_combo !== 10'd0 || multiplier !== 3'd1 ||
            drop_count !== 8'd0)
            $display("FAIL reset_values: gv=%0b g=%0d lane=%0d err=%0d score=%0d combo=%0d max=%0d mult=%0d drop=%0d, want 0s and mult=1",
                     grade_valid, grade, grade_lane, grade_err, score, combo, max_combo, multiplier, drop_count);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (grade_valid !== 1'b0)
                $display("FAIL idle_valid: cycle %0d grade_valid=%0b want 0", i, grade_valid);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        song_time             = 16'd1000;
        match_time[16*5 +: 16] = 16'd990;
        match_trigger[5]      = 1'b1;
        tick();
        match_trigger = '0;
        n_total++;
        if (grade_valid !== 1'b0)
            $display("FAIL basic_latency: grade_valid=%0b at capture edge, want 0", grade_valid);
        else n_pass++;
        tick();
        expect_grade("basic_grade", 6'd5, 2'd3, 16'd10);
        tick();
        n_total++;
        if (score !== 24'd100 || combo !== 10'd1 || max_combo !== 10'd1 || grade_valid !== 1'b0)
            $display("FAIL basic_score: score=%0d combo=%0d max=%0d gv=%0b, want 100 1 1 0",
                     score, combo, max_combo, grade_valid);
        else n_pass++;
    endtask

    // Continues from test_basic: score 100, combo 1.
    task automatic test_wrap();
        song_time              = 16'h0005;
        match_time[16*2 +: 16] = 16'hFFF0;
        match_trigger[2]       = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_grade("wrap_perfect", 6'd2, 2'd3, 16'd21);
        tick();
        n_total++;
        if (score !== 24'd200 || combo !== 10'd2)
            $display("FAIL wrap_perfect_score: score=%0d combo=%0d, want 200 2", score, combo);
        else n_pass++;
        song_time              = 16'h0000;
        match_time[16*2 +: 16] = 16'h0100;
        match_trigger[2]       = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_grade("wrap_miss", 6'd2, 2'd0, 16'd256);
        tick();
        n_total++;
        if (score !== 24'd200 || combo !== 10'd0 || max_combo !== 10'd2 || multiplier !== 3'd1)
            $display("FAIL wrap_miss_score: score=%0d combo=%0d max=%0d mult=%0d, want 200 0 2 1",
                     score, combo, max_combo, multiplier);
        else n_pass++;
    endtask

    task automatic test_grade_bounds();
        logic [15:0] errs  [6];
        logic [1:0]  gexp  [6];
        errs = '{16'd30, 16'd31, 16'd60, 16'd61, 16'd100, 16'd101};
        gexp = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        do_reset();
        song_time = 16'd1000;
        for (int i = 0; i < 6; i++) begin
            // Alternate note early/late so both error signs are exercised.
            match_time[16*10 +: 16] = (i % 2 == 0) ? 16'd1000 - errs[i] : 16'd1000 + errs[i];
            match_trigger[10] = 1'b1;
            tick();
            match_trigger = '0;
            tick();
            expect_grade($sformatf("bound_err_%0d", errs[i]), 6'd10, gexp[i], errs[i]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        song_time              = 16'd500;
        match_time[16*3 +: 16] = 16'd500;
        match_trigger[3]       = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_grade("rr_setup", 6'd3, 2'd3, 16'd0);
        match_time[16*0  +: 16] = 16'd500;
        match_time[16*36 +: 16] = 16'd450;
        match_trigger[0]  = 1'b1;
        match_trigger[3]  = 1'b1;
        match_trigger[36] = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_grade("rr_first_36", 6'd36, 2'd2, 16'd50);
        tick();
        expect_grade("rr_second_0", 6'd0, 2'd3, 16'd0);
        tick();
        expect_grade("rr_third_3", 6'd3, 2'd3, 16'd0);
        // Pointer should now sit at lane 4, so lane 4 beats lane 3.
        match_time[16*4 +: 16] = 16'd500;
        match_trigger[3] = 1'b1;
        match_trigger[4] = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_grade("rr_ptr_lane4", 6'd4, 2'd3, 16'd0);
        tick();
        expect_grade("rr_ptr_lane3", 6'd3, 2'd3, 16'd0);
        tick();
        n_total++;
        if (grade_valid !== 1'b0 || combo !== 10'd6 || score !== 24'd550)
            $display("FAIL rr_drain: gv=%0b combo=%0d score=%0d, want 0 6 550", grade_valid, combo, score);
        else n_pass++;
    endtask

    task automatic test_pause_drop();
        do_reset();
        song_time              = 16'd2000;
        pause                  = 1'b1;
        match_time[16*7 +: 16] = 16'd1950;
        match_trigger[7]       = 1'b1;
        tick();
        match_time[16*7 +: 16] = 16'd1990;
        tick();
        match_trigger = '0;
        tick();
        n_total++;
        if (drop_count !== 8'd1 || grade_valid !== 1'b0)
            $display("FAIL pause_drop: drop=%0d gv=%0b, want 1 0", drop_count, grade_valid);
        else n_pass++;
        pause = 1'b0;
        tick();
        expect_grade("pause_release", 6'd7, 2'd3, 16'd10);
        tick();
        n_total++;
        if (grade_valid !== 1'b0 || score !== 24'd100 || combo !== 10'd1)
            $display("FAIL pause_single: gv=%0b score=%0d combo=%0d, want 0 100 1", grade_valid, score, combo);
        else n_pass++;
    endtask

    task automatic test_multiplier();
        do_reset();
        song_time              = 16'd300;
        match_time[16*0 +: 16] = 16'd300;
        match_trigger[0]       = 1'b1;
        repeat (12) tick();
        match_trigger = '0;
        repeat (3) tick();
        n_total++;
        if (score !== 24'd1400 || combo !== 10'd12 || max_combo !== 10'd12 ||
            multiplier !== 3'd2 || drop_count !== 8'd0)
            $display("FAIL mult_ramp: score=%0d combo=%0d max=%0d mult=%0d drop=%0d, want 1400 12 12 2 0",
                     score, combo, max_combo, multiplier, drop_count);
        else n_pass++;
    endtask

    task automatic test_combo_saturate();
        do_reset();
        song_time              = 16'd300;
        match_time[16*1 +: 16] = 16'd300;
        match_trigger[1]       = 1'b1;
        repeat (1030) tick();
        match_trigger = '0;
        repeat (3) tick();
        n_total++;
        if (combo !== 10'd1023 || max_combo !== 10'd1023 || multiplier !== 3'd4 || score !== 24'd406000)
            $display("FAIL combo_sat: combo=%0d max=%0d mult=%0d score=%0d, want 1023 1023 4 406000",
                     combo, max_combo, multiplier, score);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_grade_bounds();
        test_back_to_back();
        test_pause_drop();
        test_multiplier();
        test_combo_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
